// File: rtl/mips_ex_alu_arb_pkg.sv
// Shared ALU op-vector bit order and datapath widths for the EX-stage ALU arbiter.
// Requesters, the arbiter and the datapath all take the op-vector bit indices from here.
`ifndef MIPS_ALU_DEFINES
`define MIPS_ALU_DEFINES
`define MIPS_DATA_WIDTH   32
`define MIPS_ALU_OP_WIDTH 14
`define MIPS_ALU_OP_ADD   0
`define MIPS_ALU_OP_ADDU  1
`define MIPS_ALU_OP_SUB   2
`define MIPS_ALU_OP_SUBU  3
`define MIPS_ALU_OP_AND   4
`define MIPS_ALU_OP_OR    5
`define MIPS_ALU_OP_XOR   6
`define MIPS_ALU_OP_NOR   7
`define MIPS_ALU_OP_SLL   8
`define MIPS_ALU_OP_SRL   9
`define MIPS_ALU_OP_SRA   10
`define MIPS_ALU_OP_SLT   11
`define MIPS_ALU_OP_SLTU  12
`define MIPS_ALU_OP_LUI   13
`endif

package mips_ex_alu_arb_pkg;
    localparam int DATA_W = `MIPS_DATA_WIDTH;
    localparam int OP_W   = `MIPS_ALU_OP_WIDTH;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [OP_W-1:0]   op_vec_t;
endpackage

// File: rtl/mips_ex_alu_arb_pick.sv
// Combinational grant selector: one-hot grant plus encoded index.
// MIPS_ALU_ARB_RR_EN selects round-robin from ptr; otherwise lowest index wins.
module mips_ex_alu_arb_pick #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
`ifdef MIPS_ALU_ARB_RR_EN
    input  logic [ID_W-1:0]    ptr,
`endif
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

`ifdef MIPS_ALU_ARB_RR_EN
    // Winner is the valid requester at the smallest circular distance from ptr.
    always_comb begin
        int  dist;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        dist  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                dist = i - int'(ptr);
                if (dist < 0) dist = dist + NUM_REQ;
                if (en && !found && valid[i] && dist == k) begin
                    gnt[i] = 1'b1;
                    idx    = ID_W'(i);
                    found  = 1'b1;
                end
            end
        end
        any = found;
    end
`else
    always_comb begin
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (en && !found && valid[i]) begin
                gnt[i] = 1'b1;
                idx    = ID_W'(i);
                found  = 1'b1;
            end
        end
        any = found;
    end
`endif

endmodule

// File: rtl/mips_ex_alu_arb.sv
// Shared EX-stage ALU arbiter with a one-entry registered response buffer.
// MIPS_ALU_ARB_RR_EN enables round-robin priority; undefined gives fixed priority (index 0 highest).
module mips_ex_alu_arb
    import mips_ex_alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_flush,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_op1,
    input  logic [NUM_REQ*32-1:0]  req_op2,
    input  logic [NUM_REQ*14-1:0]  req_op,
    output logic [DATA_W-1:0]      alu_op1,
    output logic [DATA_W-1:0]      alu_op2,
    output logic [OP_W-1:0]        alu_op,
    input  logic [DATA_W-1:0]      alu_res,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [ID_W-1:0]        rsp_id
);

    logic              grant_en;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;

    // alu_res is deliberately kept out of this path.
    assign grant_en  = (!rsp_valid || rsp_ready) && !ex_flush;
    assign req_ready = gnt;

`ifdef MIPS_ALU_ARB_RR_EN
    logic [ID_W-1:0] ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end
`endif

    mips_ex_alu_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid (req_valid),
`ifdef MIPS_ALU_ARB_RR_EN
        .ptr   (ptr),
`endif
        .en    (grant_en),
        .gnt   (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // One-hot grant makes an AND-OR mux; zero grant idles the datapath.
    always_comb begin
        alu_op1 = '0;
        alu_op2 = '0;
        alu_op  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                alu_op1 = alu_op1 | req_op1[i*32 +: 32];
                alu_op2 = alu_op2 | req_op2[i*32 +: 32];
                alu_op  = alu_op  | req_op[i*14 +: 14];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (gnt_any) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_res;
            rsp_id    <= gnt_idx;
        end else if (ex_flush || rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_ex_alu_arb.sv
// Directed, table-driven bench for mips_ex_alu_arb (NUM_REQ=3), with a small behavioural datapath.
module tb_mips_ex_alu_arb;
    import mips_ex_alu_arb_pkg::*;

    localparam int NR = 3;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_flush;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*32-1:0] req_op1;
    logic [NR*32-1:0] req_op2;
    logic [NR*14-1:0] req_op;
    logic [31:0]      alu_op1;
    logic [31:0]      alu_op2;
    logic [13:0]      alu_op;
    logic [31:0]      alu_res;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [IW-1:0]    rsp_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_ex_alu_arb #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_flush  (ex_flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .req_op    (req_op),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    // Behavioural datapath for the ops this bench uses.
    always_comb begin
        alu_res = '0;
        if (alu_op[`MIPS_ALU_OP_ADD]) alu_res = alu_op1 + alu_op2;
        if (alu_op[`MIPS_ALU_OP_SUB]) alu_res = alu_op1 - alu_op2;
        if (alu_op[`MIPS_ALU_OP_OR])  alu_res = alu_op1 | alu_op2;
    end

    // Requester 0: 5+7, requester 1: 20-3, requester 2: F0|0F.
    function automatic logic [31:0] res_of(input int id);
        case (id)
            0:       return 32'd12;
            1:       return 32'd17;
            default: return 32'hFF;
        endcase
    endfunction

    function automatic logic [31:0] op1_of(input logic [NR-1:0] g);
        case (g)
            3'b001:  return 32'd5;
            3'b010:  return 32'd20;
            3'b100:  return 32'hF0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NR-1:0] valid;
        logic          rdy;
        logic          flush;
        logic [NR-1:0] ready;
        logic          rv;
        int            id;
    } vec_t;

    vec_t tbl[14];

    task automatic setv(input int k, input logic [NR-1:0] v, input logic r, input logic f,
                        input logic [NR-1:0] rr_rdy, input int rr_id,
                        input logic [NR-1:0] fp_rdy, input int fp_id, input logic rv);
        tbl[k].valid = v;
        tbl[k].rdy   = r;
        tbl[k].flush = f;
        tbl[k].rv    = rv;
`ifdef MIPS_ALU_ARB_RR_EN
        tbl[k].ready = rr_rdy;
        tbl[k].id    = rr_id;
`else
        tbl[k].ready = fp_rdy;
        tbl[k].id    = fp_id;
`endif
    endtask

    initial begin
        logic [31:0] held;

        //   k  valid   rdy  flush RR-ready id FP-ready id rv
        setv(0,  3'b111, 1, 0, 3'b001, 0, 3'b001, 0, 1);
        setv(1,  3'b111, 1, 0, 3'b010, 1, 3'b001, 0, 1);
        setv(2,  3'b111, 1, 0, 3'b100, 2, 3'b001, 0, 1);
        setv(3,  3'b111, 1, 0, 3'b001, 0, 3'b001, 0, 1);
        setv(4,  3'b111, 1, 0, 3'b010, 1, 3'b001, 0, 1);
        setv(5,  3'b111, 1, 0, 3'b100, 2, 3'b001, 0, 1);
        setv(6,  3'b001, 1, 0, 3'b001, 0, 3'b001, 0, 1);
        setv(7,  3'b000, 1, 0, 3'b000, 0, 3'b000, 0, 0);
        setv(8,  3'b100, 1, 0, 3'b100, 2, 3'b100, 2, 1);
        setv(9,  3'b101, 1, 0, 3'b001, 0, 3'b001, 0, 1);
        setv(10, 3'b100, 1, 1, 3'b000, 0, 3'b000, 0, 0);
        setv(11, 3'b101, 1, 0, 3'b100, 2, 3'b001, 0, 1);
        setv(12, 3'b011, 1, 0, 3'b001, 0, 3'b001, 0, 1);
        setv(13, 3'b011, 1, 0, 3'b010, 1, 3'b001, 0, 1);

        req_op1   = {32'hF0, 32'd20, 32'd5};
        req_op2   = {32'h0F, 32'd3,  32'd7};
        req_op    = {14'(1 << `MIPS_ALU_OP_OR), 14'(1 << `MIPS_ALU_OP_SUB), 14'(1 << `MIPS_ALU_OP_ADD)};
        req_valid = '0;
        rsp_ready = 1'b0;
        ex_flush  = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data",  rsp_data, 32'd0);
        chk("reset_rsp_id",    32'(rsp_id), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_alu_op",    32'(alu_op), 32'd0);

        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            req_valid = tbl[k].valid;
            rsp_ready = tbl[k].rdy;
            ex_flush  = tbl[k].flush;
            #1;
            chk($sformatf("v%0d_req_ready", k), 32'(req_ready), 32'(tbl[k].ready));
            chk($sformatf("v%0d_alu_op1", k), alu_op1, op1_of(tbl[k].ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rsp_valid", k), 32'(rsp_valid), 32'(tbl[k].rv));
            chk($sformatf("v%0d_rsp_id", k), 32'(rsp_id), 32'(tbl[k].id));
            chk($sformatf("v%0d_rsp_data", k), rsp_data, res_of(tbl[k].id));
        end

        // Backpressure: full buffer, consumer stalled for 3 cycles.
        held = rsp_data;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 3'b010;
            rsp_ready = 1'b0;
            ex_flush  = 1'b0;
            #1;
            chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d_alu_op", c), 32'(alu_op), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rsp_data", c), rsp_data, held);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req_ready", 32'(req_ready), 32'b010);
        @(posedge clk);
        #1;
        chk("bp_release_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_release_rsp_id",    32'(rsp_id), 32'd1);
        chk("bp_release_rsp_data",  rsp_data, 32'd17);

        // Asynchronous reset mid-cycle with a full buffer.
        @(negedge clk);
        req_valid = 3'b000;
        rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_rsp_data",  rsp_data, 32'd0);
        chk("async_rst_rsp_id",    32'(rsp_id), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 3'b111;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'b001);
        @(posedge clk);
        #1;
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post_rst_rsp_id",    32'(rsp_id), 32'd0);
        chk("post_rst_rsp_data",  rsp_data, 32'd12);

        @(negedge clk);
        req_valid = '0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
